// File: rtl/lsu_pkg.sv
// Shared types, funct3 constants and decode helpers for the load/store alignment unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    typedef struct packed {
        logic        write;
        logic [2:0]  funct3;
        logic [1:0]  off;
        logic [31:0] wdata;
    } lsu_req_t;

    // Access size in bytes: 1, 2 or 4.
    function automatic logic [2:0] f3_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic f3_legal(input logic wr, input logic [2:0] f3);
        if (wr)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // An access spills into the next word when offset + size > 4.
    function automatic logic misaligned(input logic [1:0] off, input logic [2:0] size);
        return ({2'b00, off} + {1'b0, size}) > 4'd4;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane enables and lane-positioned store data for one phase of an access.
module lsu_lane_align (
    input  logic [1:0]  offset,
    input  logic [2:0]  size,
    input  logic        phase,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata
);

    logic [3:0] span;
    logic [5:0] sh_lo;
    logic [5:0] sh_hi;

    assign span  = {2'b00, offset} + {1'b0, size};
    assign sh_lo = {1'b0, offset, 3'b000};
    assign sh_hi = 6'd32 - sh_lo;

    // Phase 0 covers lanes offset..span-1 of word w; phase 1 the spill lanes 0..span-5 of w+1.
    for (genvar n = 0; n < 4; n++) begin : g_lane
        localparam logic [3:0] LANE = 4'(n);
        assign be[n] = phase ? ((LANE + 4'd4) < span)
                             : ((LANE >= {2'b00, offset}) && (LANE < span));
    end

    assign lane_wdata = phase ? (wdata >> sh_hi) : (wdata << sh_lo);

endmodule

// File: rtl/lsu_align.sv
// Load/store alignment unit: byte-addressed requests to word accesses with lane enables.
// Define LSU_MISALIGN_EN to split misaligned accesses over two words; otherwise they fault.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int MEM_AW = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t        state;
    lsu_req_t          r;
    logic [MEM_AW-1:0] r_word;
    logic [2:0]        r_size;
    logic              accept;
    logic              req_fault;
    logic              split_next;
    logic              phase;
    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata;
    logic [31:0]       hold_lo;
    logic [31:0]       lo_nxt;
`ifdef LSU_MISALIGN_EN
    logic [31:0]       hold_hi;
    logic [31:0]       hi_nxt;
`endif
    logic [63:0]       hold_nxt;
    logic [31:0]       ld_shift;
    logic [31:0]       ld_result;
    logic              unused_addr_hi;

    assign req_ready      = (state == IDLE);
    assign accept         = req_valid && req_ready;
    assign r_size         = f3_size(r.funct3);
    assign phase          = (state == ACC1);
    assign unused_addr_hi = ^req_addr[31:MEM_AW+2];

`ifdef LSU_MISALIGN_EN
    assign req_fault  = !f3_legal(req_write, req_funct3);
    assign split_next = misaligned(r.off, r_size);
`else
    assign req_fault  = !f3_legal(req_write, req_funct3) ||
                        misaligned(req_addr[1:0], f3_size(req_funct3));
    assign split_next = 1'b0;
`endif

    lsu_lane_align u_lane (
        .offset     (r.off),
        .size       (r_size),
        .phase      (phase),
        .wdata      (r.wdata),
        .be         (lane_be),
        .lane_wdata (lane_wdata)
    );

    // Memory port is a pure decode of the access states; quiet everywhere else.
    always_comb begin
        mem_addr  = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_wdata = '0;
        if (state == ACC0 || state == ACC1) begin
            mem_addr  = phase ? (r_word + MEM_AW'(1)) : r_word;
            mem_re    = !r.write;
            mem_we    = r.write;
            mem_be    = lane_be;
            mem_wdata = r.write ? lane_wdata : 32'h0;
        end
    end

    // Result is formed from the hold register as it will look after this edge,
    // so the last access word feeds the response directly.
    always_comb begin
        lo_nxt = (state == ACC0) ? mem_rdata : hold_lo;
`ifdef LSU_MISALIGN_EN
        hi_nxt   = (state == ACC1) ? mem_rdata : hold_hi;
        hold_nxt = {hi_nxt, lo_nxt};
`else
        hold_nxt = {32'h0, lo_nxt};
`endif
        ld_shift = 32'(hold_nxt >> {r.off, 3'b000});
        case (r.funct3)
            F3_B:    ld_result = {{24{ld_shift[7]}}, ld_shift[7:0]};
            F3_BU:   ld_result = {24'h0, ld_shift[7:0]};
            F3_H:    ld_result = {{16{ld_shift[15]}}, ld_shift[15:0]};
            F3_HU:   ld_result = {16'h0, ld_shift[15:0]};
            default: ld_result = ld_shift;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            r         <= '0;
            r_word    <= '0;
            hold_lo   <= '0;
`ifdef LSU_MISALIGN_EN
            hold_hi   <= '0;
`endif
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_fault <= 1'b0;
        end else begin
            hold_lo   <= lo_nxt;
`ifdef LSU_MISALIGN_EN
            hold_hi   <= hi_nxt;
`endif
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        r.write  <= req_write;
                        r.funct3 <= req_funct3;
                        r.off    <= req_addr[1:0];
                        r.wdata  <= req_wdata;
                        r_word   <= req_addr[MEM_AW+1:2];
                        if (req_fault) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_fault <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state <= ACC0;
                        end
                    end
                end
                ACC0: begin
                    if (split_next) begin
                        state <= ACC1;
                    end else begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_fault <= 1'b0;
                        rsp_rdata <= r.write ? 32'h0 : ld_result;
                    end
                end
`ifdef LSU_MISALIGN_EN
                ACC1: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_fault <= 1'b0;
                    rsp_rdata <= r.write ? 32'h0 : ld_result;
                end
`endif
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_align.sv
// Bench for lsu_align: vector table through a response scoreboard, plus reset during an access.
module tb_lsu_align;
    import lsu_pkg::*;

    localparam int MEM_AW = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [2:0]        req_funct3 = 3'b0;
    logic [31:0]       req_addr = 32'h0;
    logic [31:0]       req_wdata = 32'h0;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_fault;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    always #5 clk = ~clk;

    lsu_align #(.MEM_AW(MEM_AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Word memory with per-byte write enables and combinational read.
    logic [31:0] mem [0:255];
    logic        mem_clear = 1'b1;
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end
    assign mem_rdata = mem[mem_addr];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] rd;
        logic        f;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    always @(negedge clk) begin
        if (reset_n && rsp_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rsp: got rsp_valid=1, expected none pending");
            end else begin
                e = sb.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rd);
                chk("rsp_fault", 32'(rsp_fault), 32'(e.f));
            end
        end
    end

    typedef struct {
        logic        w;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] erd;
        logic        ef;
        int          lat;
        logic [3:0]  be0;
        logic [7:0]  wd0;
        logic [3:0]  be1;
        logic [7:0]  wd1;
    } vec_t;
    vec_t vt[$];

    task automatic add(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] erd, input logic ef, input int lat,
                       input logic [3:0] be0, input logic [7:0] wd0,
                       input logic [3:0] be1, input logic [7:0] wd1);
        vec_t v;
        v.w = w; v.f3 = f3; v.a = a; v.d = d; v.erd = erd; v.ef = ef; v.lat = lat;
        v.be0 = be0; v.wd0 = wd0; v.be1 = be1; v.wd1 = wd1;
        vt.push_back(v);
    endtask

    task automatic do_req(input vec_t v, input int idx);
        int lat;
        @(negedge clk);
        chk($sformatf("v%0d req_ready", idx), 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = v.w; req_funct3 = v.f3; req_addr = v.a; req_wdata = v.d;
        @(posedge clk);
        sb.push_back({v.erd, v.ef});
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        if (v.lat == 1) begin
            chk($sformatf("v%0d strobes", idx), 32'({mem_re, mem_we}), 32'd0);
        end else begin
            chk($sformatf("v%0d be0", idx), 32'(mem_be), 32'(v.be0));
            chk($sformatf("v%0d addr0", idx), 32'(mem_addr), 32'(v.wd0));
            chk($sformatf("v%0d re/we0", idx), 32'({mem_re, mem_we}), 32'({!v.w, v.w}));
        end
        lat = 1;
        if (v.lat == 3) begin
            @(negedge clk);
            lat = 2;
            chk($sformatf("v%0d be1", idx), 32'(mem_be), 32'(v.be1));
            chk($sformatf("v%0d addr1", idx), 32'(mem_addr), 32'(v.wd1));
        end
        while (!rsp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int cnt;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        chk("reset rsp_fault", 32'(rsp_fault), 32'd0);
        chk("reset mem ctl", 32'({mem_re, mem_we, mem_be, mem_addr}), 32'd0);
        chk("reset mem_wdata", mem_wdata, 32'd0);
        mem_clear = 1'b0;
        reset_n   = 1'b1;

        //   w  f3      addr          wdata         exp rdata     flt lat be0    w0    be1    w1
        add(1, F3_W,  32'h10,       32'hDEADBEEF, 32'h0,        0, 2, 4'hF, 8'd4,   4'h0, 8'd0);
        add(0, F3_W,  32'h10,       32'h0,        32'hDEADBEEF, 0, 2, 4'hF, 8'd4,   4'h0, 8'd0);
        add(1, F3_B,  32'h21,       32'h00000081, 32'h0,        0, 2, 4'h2, 8'd8,   4'h0, 8'd0);
        add(0, F3_B,  32'h21,       32'h0,        32'hFFFFFF81, 0, 2, 4'h2, 8'd8,   4'h0, 8'd0);
        add(0, F3_BU, 32'h21,       32'h0,        32'h00000081, 0, 2, 4'h2, 8'd8,   4'h0, 8'd0);
        add(1, F3_H,  32'h32,       32'h0000A5F0, 32'h0,        0, 2, 4'hC, 8'd12,  4'h0, 8'd0);
        add(0, F3_H,  32'h32,       32'h0,        32'hFFFFA5F0, 0, 2, 4'hC, 8'd12,  4'h0, 8'd0);
        add(0, F3_HU, 32'h32,       32'h0,        32'h0000A5F0, 0, 2, 4'hC, 8'd12,  4'h0, 8'd0);
        add(0, F3_B,  32'h13,       32'h0,        32'hFFFFFFDE, 0, 2, 4'h8, 8'd4,   4'h0, 8'd0);
        add(0, F3_BU, 32'h11,       32'h0,        32'h000000BE, 0, 2, 4'h2, 8'd4,   4'h0, 8'd0);
        add(0, F3_H,  32'h12,       32'h0,        32'hFFFFDEAD, 0, 2, 4'hC, 8'd4,   4'h0, 8'd0);
        add(0, F3_HU, 32'h10,       32'h0,        32'h0000BEEF, 0, 2, 4'h3, 8'd4,   4'h0, 8'd0);
        add(1, 3'b011, 32'h10,      32'h12345678, 32'h0,        1, 1, 4'h0, 8'd0,   4'h0, 8'd0);
        add(0, 3'b110, 32'h10,      32'h0,        32'h0,        1, 1, 4'h0, 8'd0,   4'h0, 8'd0);
        add(1, F3_BU, 32'h10,       32'h12345678, 32'h0,        1, 1, 4'h0, 8'd0,   4'h0, 8'd0);
        add(0, F3_W,  32'h10,       32'h0,        32'hDEADBEEF, 0, 2, 4'hF, 8'd4,   4'h0, 8'd0);
        add(0, F3_W,  32'hFFFFFC10, 32'h0,        32'hDEADBEEF, 0, 2, 4'hF, 8'd4,   4'h0, 8'd0);
        add(1, F3_W,  32'h3FC,      32'h56780000, 32'h0,        0, 2, 4'hF, 8'd255, 4'h0, 8'd0);
        add(1, F3_W,  32'h0,        32'h00001234, 32'h0,        0, 2, 4'hF, 8'd0,   4'h0, 8'd0);
        add(0, F3_B,  32'h3FF,      32'h0,        32'h00000056, 0, 2, 4'h8, 8'd255, 4'h0, 8'd0);
        add(0, F3_HU, 32'h0,        32'h0,        32'h00001234, 0, 2, 4'h3, 8'd0,   4'h0, 8'd0);
`ifdef LSU_MISALIGN_EN
        add(1, F3_W,  32'h0E,       32'h44332211, 32'h0,        0, 3, 4'hC, 8'd3,   4'h3, 8'd4);
        add(0, F3_W,  32'h0E,       32'h0,        32'h44332211, 0, 3, 4'hC, 8'd3,   4'h3, 8'd4);
        add(0, F3_HU, 32'h0F,       32'h0,        32'h00003322, 0, 3, 4'h8, 8'd3,   4'h1, 8'd4);
        add(1, F3_H,  32'h07,       32'h00008001, 32'h0,        0, 3, 4'h8, 8'd1,   4'h1, 8'd2);
        add(0, F3_H,  32'h07,       32'h0,        32'hFFFF8001, 0, 3, 4'h8, 8'd1,   4'h1, 8'd2);
        add(0, F3_W,  32'h3FE,      32'h0,        32'h12345678, 0, 3, 4'hC, 8'd255, 4'h3, 8'd0);
`else
        add(1, F3_W,  32'h0E,       32'h44332211, 32'h0,        1, 1, 4'h0, 8'd0,   4'h0, 8'd0);
        add(0, F3_W,  32'h0E,       32'h0,        32'h0,        1, 1, 4'h0, 8'd0,   4'h0, 8'd0);
        add(0, F3_H,  32'h07,       32'h0,        32'h0,        1, 1, 4'h0, 8'd0,   4'h0, 8'd0);
        add(1, F3_H,  32'h07,       32'h00008001, 32'h0,        1, 1, 4'h0, 8'd0,   4'h0, 8'd0);
        add(0, F3_W,  32'h3FE,      32'h0,        32'h0,        1, 1, 4'h0, 8'd0,   4'h0, 8'd0);
        add(0, F3_W,  32'h0C,       32'h0,        32'h0,        0, 2, 4'hF, 8'd3,   4'h0, 8'd0);
        add(0, F3_W,  32'h04,       32'h0,        32'h0,        0, 2, 4'hF, 8'd1,   4'h0, 8'd0);
        add(0, F3_W,  32'h10,       32'h0,        32'hDEADBEEF, 0, 2, 4'hF, 8'd4,   4'h0, 8'd0);
`endif
        for (int i = 0; i < vt.size(); i++) do_req(vt[i], i);

        // Reset landing on the last access cycle must abort without a response.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = F3_W;
`ifdef LSU_MISALIGN_EN
        req_addr = 32'h3FE;
`else
        req_addr = 32'h10;
`endif
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
`ifdef LSU_MISALIGN_EN
        @(negedge clk);
        chk("midrst acc1 addr", 32'(mem_addr), 32'd0);
`endif
        chk("midrst mem_re", 32'(mem_re), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst req_ready", 32'(req_ready), 32'd1);
        chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst mem_re", 32'(mem_re), 32'd0);
        chk("midrst rsp_rdata", rsp_rdata, 32'd0);
        reset_n = 1'b1;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
        end
        chk("midrst no_rsp", 32'(cnt), 32'd0);

        begin
            vec_t v;
            v.w = 1'b0; v.f3 = F3_B; v.a = 32'h3FF; v.d = 32'h0; v.erd = 32'h00000056;
            v.ef = 1'b0; v.lat = 2; v.be0 = 4'h8; v.wd0 = 8'd255; v.be1 = 4'h0; v.wd1 = 8'd0;
            do_req(v, 99);
        end

        @(negedge clk);
        chk("sb drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
